// File: rtl/spi_ctrl_pkg.sv
// Shared frame layout, register map and FSM states for the SPI mode-0 controller.
package spi_ctrl_pkg;

  localparam int FRAME_W  = 16;
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'd3;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'd4;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  function automatic logic [FRAME_W-1:0] pack_frame(input logic       wr,
                                                    input logic [6:0] addr,
                                                    input logic [7:0] data);
    return {wr, addr, data};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider: toggles every CLK_DIV enabled cycles, starting low.
// Held at div_cnt=0 / SCLK low whenever en is low.
module spi_sclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic tick,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // tick is the raw end-of-half-period flag; the strobes mark the edge at which SCLK toggles.
  assign tick     = (div_cnt == DIV_LAST);
  assign rise_stb = en && tick && !sclk;
  assign fall_stb = en && tick && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 frame originator: 16-bit {R/W, addr[6:0], data[7:0]} MSB-first on nCS/SCLK/COPI.
// Optional SPI_CTRL_READBACK_EN adds cipo sampling and rd_data for read frames.
module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI
`ifdef SPI_CTRL_READBACK_EN
  ,
  input  logic       cipo,
  output logic [7:0] rd_data
`endif
);

  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("spi_controller: CLK_DIV must be >= 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("spi_controller: GAP_CYCLES must be >= 1");
    end
  endgenerate

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t               state, state_nx;
  logic [FRAME_W-1:0]   shift_q;
  logic [3:0]           bit_cnt;
  logic                 last_q;
  logic [GW-1:0]        gap_cnt;
  logic                 accept;
  logic                 end_frame;
  logic                 gap_done;
  logic                 sclk_en;
  logic                 tick;
  logic                 rise_stb;
  logic                 fall_stb;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  // The frame ends on the 33rd half-period boundary, after the low half that follows bit 0.
  assign end_frame = (state == SHIFT) && last_q && tick;
  assign gap_done  = (state == GAP) && (gap_cnt == GAP_LAST);
  assign sclk_en   = ((state == SETUP) || (state == SHIFT)) && !end_frame;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (sclk_en),
    .sclk     (SCLK),
    .tick     (tick),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = SETUP;
      SETUP:   if (rise_stb)  state_nx = SHIFT;
      SHIFT:   if (end_frame) state_nx = GAP;
      GAP:     if (gap_done)  state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bit_cnt <= '0;
      last_q  <= 1'b0;
      gap_cnt <= '0;
      nCS     <= 1'b1;
      COPI    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_q <= pack_frame(req_write, req_addr, req_data);
            nCS     <= 1'b0;
            COPI    <= req_write;
            busy    <= 1'b1;
            bit_cnt <= '0;
            last_q  <= 1'b0;
          end
        end
        SETUP: begin
          if (rise_stb) bit_cnt <= 4'd15;
        end
        SHIFT: begin
          if (end_frame) begin
            nCS  <= 1'b1;
            COPI <= 1'b0;
            done <= 1'b1;
          end else if (fall_stb) begin
            // Fall after bit 0 leaves COPI alone and arms the final low half-period.
            if (bit_cnt != 4'd0) begin
              COPI    <= shift_q[bit_cnt - 4'd1];
              bit_cnt <= bit_cnt - 4'd1;
            end else begin
              last_q <= 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_done) begin
            gap_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_CTRL_READBACK_EN
  logic [7:0] rd_shift;

  // Read frames: collect cipo at the rises of data bits 7..0, publish on frame completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_shift <= '0;
      rd_data  <= '0;
    end else begin
      if ((state == SHIFT) && rise_stb && !shift_q[RW_BIT] && (bit_cnt <= 4'd7))
        rd_shift <= {rd_shift[6:0], cipo};
      if (end_frame && !shift_q[RW_BIT])
        rd_data <= rd_shift;
    end
  end
`endif

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI mode-0 controller that originates 16-bit register-write/read frames toward the chip's SPI peripheral (register map 0..4: output enables, PWM enables, PWM duty).
Accepts one request at a time over a valid/ready handshake and serialises it MSB-first on nCS/SCLK/COPI.
Frame format: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
Sits in the test/host-side harness and in any on-chip sequencer that configures the PWM block.

Parameters:
CLK_DIV, 8, clk cycles per SCLK half-period; legal >= 2, elaboration error below 2; >= 4 required for the peripheral's 3-stage input synchroniser.
GAP_CYCLES, 16, minimum clk cycles nCS stays high between frames, giving the peripheral time to commit; legal >= 1.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_write  input  1  frame bit15
req_addr  input  7  frame bits14:8
req_data  input  8  frame bits7:0
busy  output  1  high from acceptance until the end of GAP
done  output  1  one-cycle pulse when the frame completes
nCS  output  1  chip select, active-low
SCLK  output  1  serial clock, idle low
COPI  output  1  serial data to the peripheral

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, nCS=1, SCLK=0, COPI=0, done=0, busy=0, req_ready=1, all counters 0.
- All outputs are registered; no combinational path from inputs to nCS/SCLK/COPI. req_ready = (state==IDLE) and is the only combinational output.
- States:
  - IDLE: on req_valid && req_ready, latch shift={req_write,req_addr,req_data} and go to SETUP.
  - SETUP: nCS=0, SCLK=0, COPI=shift[15], all from the next cycle. Lasts CLK_DIV cycles, then go to SHIFT with bit_cnt=15.
  - SHIFT: each bit is SCLK=1 for CLK_DIV cycles, then SCLK=0 for CLK_DIV cycles. COPI changes only on the cycle SCLK falls, and only if bit_cnt>0 (next bit). bit_cnt decrements at each fall.
  - SHIFT exit: after the 16th low half-period, go to GAP. nCS=1, COPI=0, done=1 for one cycle.
  - GAP: counts GAP_CYCLES, then go to IDLE.
- Timing: nCS low for exactly 33*CLK_DIV cycles; 16 SCLK rising edges per frame; COPI stable for >= CLK_DIV cycles on both sides of each rising edge.
- Accept-to-next-accept minimum: 1 + 33*CLK_DIV + GAP_CYCLES cycles.
- req_* inputs are sampled only at acceptance; changes afterwards do not affect the frame. req_valid while busy is ignored (no queueing).
- A read frame (req_write=0) is clocked out identically.
- Reset mid-frame: the frame is truncated, nCS rises asynchronously and done is not pulsed. The caller owns recovery, since the peripheral may see a partial frame.
- Counters:
  - div_cnt width $clog2(CLK_DIV), wraps at CLK_DIV-1.
  - bit_cnt 4 bits, no underflow past 0.
  - gap_cnt width $clog2(GAP_CYCLES+1).

Optional Feature:
SPI_CTRL_READBACK_EN
- Defined: adds input cipo (1) and output rd_data (8). During frames with bit15=0, cipo is sampled on the cycle SCLK rises for bits 7..0, MSB first. rd_data updates in the done cycle and otherwise holds; reset value 0x00. Write frames leave rd_data unchanged.
- Undefined: neither port exists and no sampling logic is built.

Decomposition:
- Package spi_ctrl_pkg:
  - FRAME_W=16, RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7.
  - Register address constants: ADDR_EN_OUT_7_0=0, ADDR_EN_OUT_15_8=1, ADDR_EN_PWM_7_0=2, ADDR_EN_PWM_15_8=3, ADDR_PWM_DUTY=4.
  - State enum: IDLE, SETUP, SHIFT, GAP.
- One sub-module, spi_sclk_gen: half-period divider with enable. Produces the SCLK level plus one-cycle rise_stb/fall_stb; cleared to low/idle whenever disabled.

Test Plan:
1. CLK_DIV=4, write addr 0 data 0xA5 -> at the 16 SCLK rises COPI reads 1,0000000,10100101; nCS low exactly 132 cycles; one done pulse.
2. req_valid held high with two queued requests (0x01/0x3C, 0x04/0x80) -> second accepted only after nCS high >= GAP_CYCLES; req_ready=0 throughout the first frame.
3. Change req_addr/req_data and pulse req_valid mid-frame -> COPI bits unchanged, no extra acceptance.
4. Assert rst at bit_cnt=8 -> nCS=1, SCLK=0, COPI=0 the same cycle; no done; req_ready=1 after release; next frame is correct.
5. With SPI_CTRL_READBACK_EN, read addr 3 while a cipo model drives 0x3C -> COPI MSB=0; rd_data=0x3C in the done cycle; a following write leaves rd_data=0x3C.
6. End-to-end with the team's SPI peripheral, CLK_DIV=8: write ADDR_EN_OUT_7_0=0x5A -> peripheral en_reg_out_7_0=0x5A within GAP_CYCLES after done.
